// File: rtl/online_seq_pkg.sv
// Shared types for the online stage sequencer: signed-digit encoding and FSM states.
package online_seq_pkg;

   // One radix-2 signed digit, encoded {p,n}.
   typedef logic [1:0] digit_t;

   localparam digit_t DIG_ZERO = 2'b00;
   localparam digit_t DIG_POS  = 2'b10;
   localparam digit_t DIG_NEG  = 2'b01;
   localparam digit_t DIG_ILL  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StInit,
      StFeed,
      StDone
   } state_e;

   // Map the illegal {1,1} code onto zero; legal codes pass through.
   function automatic digit_t dig_norm(digit_t d);
      case (d)
         DIG_POS, DIG_NEG: return d;
         default:          return DIG_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/online_digit_shreg.sv
// N-digit shift register: parallel load, shifts one digit toward the MSB end per
// shift_i, new digit entering at the LSB end. Load wins over shift. Needs N >= 2.
module online_digit_shreg #(
   parameter int unsigned N = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic [2*N-1:0] load_data_i,
   input  logic           shift_i,
   input  logic [1:0]     shift_in_i,
   output logic [2*N-1:0] data_o
);

   logic [2*N-1:0] data_d, data_q;

   // Next-state: load, shift or hold.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {data_q[2*N-3:0], shift_in_i};
      end
   end

   // Digit storage with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/online_stage_sequencer.sv
// Sequences one online operation: serializes two N-digit operands MSB first into the
// PMS chain, flushes DELTA zero digits, collects N result digits and hands the word
// out with valid/ready. Define ONLINE_SEQ_DIGCHK_EN to add the sticky dig_err_o flag.
module online_stage_sequencer
   import online_seq_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned DELTA = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [2*N-1:0] x_in_i,
   input  logic [2*N-1:0] y_in_i,
   output logic           stage_clr_o,
   output logic           stage_en_o,
   output logic [1:0]     dig_x_o,
   output logic [1:0]     dig_y_o,
   input  logic [1:0]     z_dig_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [2*N-1:0] z_out_o
`ifdef ONLINE_SEQ_DIGCHK_EN
   ,
   output logic           dig_err_o
`endif
);

   localparam int unsigned CntW = $clog2(N + DELTA + 1);
   localparam logic [CntW-1:0] CntN     = CntW'(N);
   localparam logic [CntW-1:0] CntDelta = CntW'(DELTA);
   localparam logic [CntW-1:0] CntLast  = CntW'(N + DELTA - 1);

   state_e          state_d, state_q;
   logic [CntW-1:0] cnt_d, cnt_q;
   logic            in_ready;
   logic            load;
   logic            shift_op;
   logic            capture;
   logic [2*N-1:0]  x_word, y_word;

   // FSM next-state and handshake/control decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_ready    = 1'b0;
      load        = 1'b0;
      shift_op    = 1'b0;
      capture     = 1'b0;
      stage_clr_o = 1'b0;
      stage_en_o  = 1'b0;
      out_valid_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid_i) begin
               load    = 1'b1;
               state_d = StInit;
            end
         end
         StInit: begin
            stage_clr_o = 1'b1;
            cnt_d       = '0;
            state_d     = StFeed;
         end
         StFeed: begin
            stage_en_o = 1'b1;
            shift_op   = (cnt_q < CntN);
            capture    = (cnt_q >= CntDelta);
            if (cnt_q == CntLast) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            out_valid_o = 1'b1;
            // Retiring and accepting in the same cycle keeps back-to-back ops gapless.
            in_ready    = out_ready_i;
            if (out_ready_i) begin
               if (in_valid_i) begin
                  load    = 1'b1;
                  state_d = StInit;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and digit counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // in_ready must read low while reset is held, even though state_q may still be IDLE.
   assign in_ready_o = in_ready & ~rst_i;

   online_digit_shreg #(
      .N (N)
   ) u_x_shreg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load),
      .load_data_i (x_in_i),
      .shift_i     (shift_op),
      .shift_in_i  (DIG_ZERO),
      .data_o      (x_word)
   );

   online_digit_shreg #(
      .N (N)
   ) u_y_shreg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load),
      .load_data_i (y_in_i),
      .shift_i     (shift_op),
      .shift_in_i  (DIG_ZERO),
      .data_o      (y_word)
   );

   online_digit_shreg #(
      .N (N)
   ) u_z_shreg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (1'b0),
      .load_data_i ({(2*N){1'b0}}),
      .shift_i     (capture),
      .shift_in_i  (dig_norm(z_dig_i)),
      .data_o      (z_out_o)
   );

   // Only the MSB digit of each operand register is presented; the rest shift up into it.
   assign dig_x_o = shift_op ? dig_norm(x_word[2*N-1 -: 2]) : DIG_ZERO;
   assign dig_y_o = shift_op ? dig_norm(y_word[2*N-1 -: 2]) : DIG_ZERO;

   logic unused_low_digits;
   assign unused_low_digits = ^{x_word[2*N-3:0], y_word[2*N-3:0]};

`ifdef ONLINE_SEQ_DIGCHK_EN
   logic dig_err_q;

   function automatic logic has_ill(logic [2*N-1:0] w);
      logic r;
      r = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         r = r | (w[2*i +: 2] == DIG_ILL);
      end
      return r;
   endfunction

   // Sticky flag: only reset clears it, a new operation does not.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dig_err_q <= 1'b0;
      end else if ((load && (has_ill(x_in_i) || has_ill(y_in_i))) ||
                   (stage_en_o && (z_dig_i == DIG_ILL))) begin
         dig_err_q <= 1'b1;
      end
   end

   assign dig_err_o = dig_err_q;
`endif

endmodule

// File: tb/tb_online_stage_sequencer.sv
// Directed bench for online_stage_sequencer (N=4, DELTA=2) with a datapath stub that
// echoes dig_x delayed by two stage_en cycles.
module tb_online_stage_sequencer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x_in;
   logic [7:0] y_in;
   logic       stage_clr;
   logic       stage_en;
   logic [1:0] dig_x;
   logic [1:0] dig_y;
   logic [1:0] z_dig;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] z_out;
`ifdef ONLINE_SEQ_DIGCHK_EN
   logic       dig_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   online_stage_sequencer #(
      .N     (4),
      .DELTA (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .x_in_i      (x_in),
      .y_in_i      (y_in),
      .stage_clr_o (stage_clr),
      .stage_en_o  (stage_en),
      .dig_x_o     (dig_x),
      .dig_y_o     (dig_y),
      .z_dig_i     (z_dig),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .z_out_o     (z_out)
`ifdef ONLINE_SEQ_DIGCHK_EN
      ,
      .dig_err_o   (dig_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stub: two-deep digit pipe advanced by stage_en, cleared by stage_clr.
   logic [1:0] pipe0, pipe1;
   logic       z_force;
   always @(posedge clk) begin
      if (rst || stage_clr) begin
         pipe0 <= 2'b00;
         pipe1 <= 2'b00;
      end else if (stage_en) begin
         pipe1 <= pipe0;
         pipe0 <= dig_x;
      end
   end
   assign z_dig = z_force ? 2'b11 : pipe1;

   typedef struct {
      logic       iv;
      logic [7:0] x;
      logic [7:0] y;
      logic       ordy;
      logic       e_ir;
      logic       e_clr;
      logic       e_en;
      logic [1:0] e_dx;
      logic [1:0] e_dy;
      logic       e_ov;
      logic       cz;
      logic [7:0] e_z;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [7:0] x, input logic [7:0] y,
                      input logic ordy, input logic e_ir, input logic e_clr,
                      input logic e_en, input logic [1:0] e_dx, input logic [1:0] e_dy,
                      input logic e_ov, input logic cz, input logic [7:0] e_z);
      vec_t v;
      v.iv = iv; v.x = x; v.y = y; v.ordy = ordy;
      v.e_ir = e_ir; v.e_clr = e_clr; v.e_en = e_en; v.e_dx = e_dx; v.e_dy = e_dy;
      v.e_ov = e_ov; v.cz = cz; v.e_z = e_z;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_ov;
      rst = 1'b1; in_valid = 1'b0; x_in = 8'h00; y_in = 8'h00; out_ready = 1'b0;
      z_force = 1'b0;
      step(); step(); step();
      #1;
      chk("rst in_ready", {7'b0, in_ready}, 8'd0);
      chk("rst out_valid", {7'b0, out_valid}, 8'd0);
      chk("rst stage_clr", {7'b0, stage_clr}, 8'd0);
      chk("rst stage_en", {7'b0, stage_en}, 8'd0);
      chk("rst dig_x", {6'b0, dig_x}, 8'd0);
      chk("rst z_out", z_out, 8'h00);
`ifdef ONLINE_SEQ_DIGCHK_EN
      chk("rst dig_err", {7'b0, dig_err}, 8'd0);
`endif
      step();

      // T1/T2: op X=10_00_01_00, Y=01_10_00_10, result held 5 cycles then retired.
      //   iv x      y      or ir clr en dx     dy     ov cz z
      add(1, 8'h84, 8'h62, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b10, 2'b01, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 8'h00);
      add(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) add(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 8'h84);
      add(0, 8'h00, 8'h00, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 8'h84);
      // T3: op X=00_10_00_01, then back-to-back X=01_01_01_01 loaded in the DONE cycle.
      add(1, 8'h21, 8'h00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 8'h84);
      add(0, 8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(1, 8'h55, 8'h00, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 8'h21);
      add(0, 8'h00, 8'h00, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 8'h00);
      add(0, 8'h00, 8'h00, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 8'h55);
      add(0, 8'h00, 8'h00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 8'h55);

      rst = 1'b0;
      foreach (vecs[r]) begin
         in_valid = vecs[r].iv; x_in = vecs[r].x; y_in = vecs[r].y;
         out_ready = vecs[r].ordy;
         #1;
         chk($sformatf("v%0d in_ready", r), {7'b0, in_ready}, {7'b0, vecs[r].e_ir});
         chk($sformatf("v%0d stage_clr", r), {7'b0, stage_clr}, {7'b0, vecs[r].e_clr});
         chk($sformatf("v%0d stage_en", r), {7'b0, stage_en}, {7'b0, vecs[r].e_en});
         chk($sformatf("v%0d dig_x", r), {6'b0, dig_x}, {6'b0, vecs[r].e_dx});
         chk($sformatf("v%0d dig_y", r), {6'b0, dig_y}, {6'b0, vecs[r].e_dy});
         chk($sformatf("v%0d out_valid", r), {7'b0, out_valid}, {7'b0, vecs[r].e_ov});
         if (vecs[r].cz) chk($sformatf("v%0d z_out", r), z_out, vecs[r].e_z);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
`ifdef ONLINE_SEQ_DIGCHK_EN
      #1;
      chk("legal ops dig_err", {7'b0, dig_err}, 8'd0);
`endif

      // T4: reset during FEED at cnt=3 drops the operation.
      in_valid = 1'b1; x_in = 8'h84; y_in = 8'h00;
      step();
      in_valid = 1'b0;
      step(); step(); step(); step();
      rst = 1'b1;
      #1;
      chk("t4 feed before abort", {7'b0, stage_en}, 8'd1);
      step();
      rst = 1'b0;
      #1;
      chk("t4 in_ready", {7'b0, in_ready}, 8'd1);
      chk("t4 stage_en", {7'b0, stage_en}, 8'd0);
      chk("t4 stage_clr", {7'b0, stage_clr}, 8'd0);
      chk("t4 dig_x", {6'b0, dig_x}, 8'd0);
      chk("t4 out_valid", {7'b0, out_valid}, 8'd0);
      chk("t4 z_out", z_out, 8'h00);
      seen_ov = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen_ov = seen_ov | out_valid;
      end
      chk("t4 no out_valid after abort", {7'b0, seen_ov}, 8'd0);

      // T5: illegal digits, X=11_00_01_00, plus an illegal z_dig on the first capture.
      in_valid = 1'b1; x_in = 8'hC4; y_in = 8'h00;
      step();
      in_valid = 1'b0;
      #1;
      chk("t5 stage_clr", {7'b0, stage_clr}, 8'd1);
`ifdef ONLINE_SEQ_DIGCHK_EN
      chk("t5 dig_err after load", {7'b0, dig_err}, 8'd1);
`endif
      step();
      chk("t5 dig_x cnt0 normalized", {6'b0, dig_x}, 8'd0);
      step();
      chk("t5 dig_x cnt1", {6'b0, dig_x}, 8'd0);
      step();
      z_force = 1'b1;
      #1;
      chk("t5 dig_x cnt2", {6'b0, dig_x}, 8'd1);
      step();
      z_force = 1'b0;
      step(); step(); step();
      chk("t5 out_valid", {7'b0, out_valid}, 8'd1);
      chk("t5 z_out normalized", z_out, 8'h04);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      chk("t5 out_valid retired", {7'b0, out_valid}, 8'd0);
`ifdef ONLINE_SEQ_DIGCHK_EN
      chk("t5 dig_err sticky", {7'b0, dig_err}, 8'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t5 dig_err cleared by rst", {7'b0, dig_err}, 8'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
